// File: rtl/fwd_if.sv
// fwd_if: ID-side instruction fields into the forwarding controller and its select/stall results back out.
interface fwd_if #(parameter int REGW = 5, parameter int CNTW = 16);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic [REGW-1:0] id_rd;
  logic            id_regwrite;
  logic            id_memread;
  logic            flush;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  logic            ex_valid;
  logic            stall;
  logic [CNTW-1:0] stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
    input  sel_a, sel_b, ex_valid, stall, stall_count
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
    output sel_a, sel_b, ex_valid, stall, stall_count
  );
endinterface

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX/MEM destination shadow driving ALU operand forwarding selects, load-use stall and stall counter.
module fwd_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic reset,
  fwd_if.slave f
);
  logic            ex_v, ex_rw, ex_mr, mem_wr;
  logic [REGW-1:0] ex_d, mem_d;
  logic [1:0]      sel_a, sel_b;
  logic [CNTW-1:0] cnt;
  logic            ex_wr, stall, take;
  // WB is never a forwarding source (write-before-read register file), so only EX and MEM are kept.
  assign ex_wr = ex_v & ex_rw & (ex_d != '0);
  assign stall = f.id_valid & !f.flush & ex_wr & ex_mr & (ex_d == f.id_rs | ex_d == f.id_rt);
  assign take  = f.id_valid & !f.flush & !stall;
  function automatic logic [1:0] sel_of(input logic [REGW-1:0] s);
    return (s == '0) ? 2'b11 : (ex_wr && s == ex_d) ? 2'b01 : (mem_wr && s == mem_d) ? 2'b10 : 2'b00;
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v   <= 1'b0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      ex_d   <= '0;
      mem_wr <= 1'b0;
      mem_d  <= '0;
      sel_a  <= 2'b00;
      sel_b  <= 2'b00;
      cnt    <= '0;
    end else begin
      mem_wr <= ex_wr;
      mem_d  <= ex_d;
      ex_v   <= take;
      ex_rw  <= take & f.id_regwrite;
      ex_mr  <= take & f.id_memread;
      ex_d   <= take ? f.id_rd : '0;
      sel_a  <= take ? sel_of(f.id_rs) : 2'b00;
      sel_b  <= take ? sel_of(f.id_rt) : 2'b00;
      cnt    <= (stall && !(&cnt)) ? cnt + CNTW'(1) : cnt;
    end
  end
  assign f.sel_a       = sel_a;
  assign f.sel_b       = sel_b;
  assign f.ex_valid    = ex_v;
  assign f.stall       = stall;
  assign f.stall_count = cnt;
endmodule
